cost: RTL

- Output-layer error generator for training; sits on the far end of the sigmoid activation unit's result/error interfaces.
- Consumes the 8-bit activation result stream and an 8-bit target stream, and returns a scaled 16-bit signed error to the activation unit's error input.
- In inference mode (en low) it only drains activations and issues no error.

---
 rtl/cost.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cost.sv
// Output-layer error generator: err = (target - activation) <<< SHIFT, signed Q8.8.
// Optional `LOSS_EN adds a sum-of-squared-differences report every COUNT samples.
module cost #(
    parameter int unsigned SHIFT = 0,
    parameter int unsigned COUNT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        act_stb,
    input  logic [7:0]  act_dat,
    output logic        act_rdy,
    input  logic        tgt_stb,
    input  logic [7:0]  tgt_dat,
    output logic        tgt_rdy,
    output logic        err_stb,
    output logic [15:0] err_dat,
    input  logic        err_rdy,
    output logic        loss_stb,
    output logic [31:0] loss_dat,
    input  logic        loss_rdy
);

    typedef enum logic [1:0] {RCV = 2'b01, ERR = 2'b10} state_t;

    state_t             state, state_n;
    logic               act_have, tgt_have;
    logic [7:0]         act_q, tgt_q;
    logic               act_fire, tgt_fire, err_fire;
    logic               loss_block;
    logic signed [8:0]  diff;
    logic [15:0]        diff_ext;
    logic [15:0]        shifted;

    assign diff     = $signed({1'b0, tgt_q}) - $signed({1'b0, act_q});
    assign diff_ext = {{7{diff[8]}}, diff};
    assign shifted  = diff_ext << SHIFT;

    assign act_fire = act_stb & act_rdy;
    assign tgt_fire = tgt_stb & tgt_rdy;
    assign err_fire = err_stb & err_rdy;

`ifdef LOSS_EN
    assign loss_block = loss_stb;
`else
    assign loss_block = 1'b0;
`endif

    always_comb begin
        state_n = state;
        act_rdy = 1'b0;
        tgt_rdy = 1'b0;
        case (state)
            RCV: begin
                act_rdy = !act_have && !loss_block;
                tgt_rdy = !tgt_have;
                if (act_have && tgt_have)
                    state_n = ERR;
            end
            ERR: begin
                if (err_fire)
                    state_n = RCV;
            end
            default: state_n = RCV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RCV;
            act_have <= 1'b0;
            tgt_have <= 1'b0;
            act_q    <= '0;
            tgt_q    <= '0;
            err_stb  <= 1'b0;
            err_dat  <= '0;
        end else begin
            state <= state_n;
            // en==0 discards the activation: data is latched but the flag stays low
            if (act_fire) begin
                act_q    <= act_dat;
                act_have <= en;
            end
            if (tgt_fire) begin
                tgt_q    <= tgt_dat;
                tgt_have <= 1'b1;
            end
            if (state == RCV && act_have && tgt_have) begin
                err_dat <= shifted;
                err_stb <= 1'b1;
            end
            if (err_fire) begin
                err_stb  <= 1'b0;
                act_have <= 1'b0;
                tgt_have <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst && state != RCV && state != ERR)
            $fatal(1, "cost: illegal state encoding %b", state);
    end
`endif

`ifdef LOSS_EN
    localparam logic [15:0] LAST = 16'(COUNT - 1);

    logic [31:0] acc;
    logic [15:0] cnt;
    logic [7:0]  mag;
    logic [15:0] sq;

    // act_q/tgt_q are still held on the ack edge, so the square needs no extra register
    assign mag = diff[8] ? 8'(-diff) : 8'(diff);
    assign sq  = 16'(mag) * 16'(mag);

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc      <= '0;
            cnt      <= '0;
            loss_stb <= 1'b0;
            loss_dat <= '0;
        end else begin
            if (loss_stb && loss_rdy)
                loss_stb <= 1'b0;
            if (err_fire) begin
                if (cnt == LAST) begin
                    loss_dat <= acc + 32'(sq);
                    loss_stb <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= acc + 32'(sq);
                    cnt <= cnt + 16'd1;
                end
            end
        end
    end
`else
    logic unused_loss_rdy;
    assign unused_loss_rdy = loss_rdy;
    assign loss_stb = 1'b0;
    assign loss_dat = '0;
`endif

endmodule
